// File: rtl/rvm_ctrl_seq.sv
// rtl/rvm_ctrl_seq.sv - multi-cycle RISC-V control sequencer with bus handshakes, watchdog traps and debug halt
// Strobes decode from the current state; only ir_we also qualifies on the fetch response.
module rvm_ctrl_seq #(
    parameter int TIMEOUT = 16,
    parameter int TMO_W   = 8,
    parameter int CNT_W   = 64
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    input  logic             imem_ack,
    input  logic             imem_err,
    output logic             dmem_req,
    output logic             dmem_wen,
    input  logic             dmem_ack,
    input  logic             dmem_err,
    input  logic [2:0]       dec_class,
    input  logic             dec_wb,
    input  logic             dec_illegal,
    output logic             exec_start,
    input  logic             exec_done,
    output logic             ir_we,
    output logic             pc_we,
    output logic             rf_we,
    output logic             trap,
    output logic [3:0]       trap_cause,
    input  logic             halt_req,
    output logic             halted,
    output logic [CNT_W-1:0] instret,
    output logic [3:0]       state
);

    typedef enum logic [3:0] {
        S_RESET     = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_EXECUTE   = 4'd3,
        S_EXEC_WAIT = 4'd4,
        S_MEMORY    = 4'd5,
        S_WRITEBACK = 4'd6,
        S_TRAP      = 4'd7,
        S_HALT      = 4'd8
    } state_t;

    localparam logic [2:0] C_ALU    = 3'd0;
    localparam logic [2:0] C_BRANCH = 3'd1;
    localparam logic [2:0] C_LOAD   = 3'd2;
    localparam logic [2:0] C_STORE  = 3'd3;
    localparam logic [2:0] C_MULTI  = 3'd4;
    localparam logic [2:0] C_SYSTEM = 3'd5;

    localparam int               TMO_LIM_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [TMO_W-1:0] TMO_LIM   = TMO_LIM_I[TMO_W-1:0];
    localparam bit               TMO_EN    = (TIMEOUT != 0);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   instret_q, instret_d;
    logic [3:0]         trap_cause_q, trap_cause_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [2:0]         cls_q, cls_d;
    logic               wb_q, wb_d;
    logic               tmo_hit;

    // A wait state that has already stalled TIMEOUT-1 cycles traps now unless its response arrives.
    assign tmo_hit = TMO_EN && (tmo_q == TMO_LIM);

    always_comb begin
        state_d      = state_q;
        instret_d    = instret_q;
        trap_cause_d = trap_cause_q;
        cls_d        = cls_q;
        wb_d         = wb_q;
        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ack) begin
                    if (imem_err) begin
                        state_d      = S_TRAP;
                        trap_cause_d = 4'd1;
                    end else begin
                        state_d = S_DECODE;
                    end
                end else if (tmo_hit) begin
                    state_d      = S_TRAP;
                    trap_cause_d = 4'd2;
                end
            end
            S_DECODE: begin
                cls_d = dec_class;
                wb_d  = dec_wb;
                if (dec_illegal || (dec_class > C_SYSTEM)) begin
                    state_d      = S_TRAP;
                    trap_cause_d = 4'd3;
                end else begin
                    state_d = S_EXECUTE;
                end
            end
            S_EXECUTE: begin
                case (cls_q)
                    C_ALU, C_BRANCH: state_d = S_WRITEBACK;
                    C_LOAD, C_STORE: state_d = S_MEMORY;
                    C_MULTI:         state_d = S_EXEC_WAIT;
                    default: begin
                        state_d      = S_TRAP;
                        trap_cause_d = 4'd4;
                    end
                endcase
            end
            S_EXEC_WAIT: begin
                if (exec_done) begin
                    state_d = S_WRITEBACK;
                end else if (tmo_hit) begin
                    state_d      = S_TRAP;
                    trap_cause_d = 4'd5;
                end
            end
            S_MEMORY: begin
                if (dmem_ack) begin
                    if (dmem_err) begin
                        state_d      = S_TRAP;
                        trap_cause_d = (cls_q == C_STORE) ? 4'd7 : 4'd6;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end else if (tmo_hit) begin
                    state_d      = S_TRAP;
                    trap_cause_d = 4'd8;
                end
            end
            S_WRITEBACK: begin
                instret_d = instret_q + CNT_W'(1);
                state_d   = halt_req ? S_HALT : S_FETCH;
            end
            S_TRAP: state_d = halt_req ? S_HALT : S_FETCH;
            S_HALT: begin
                if (!halt_req) state_d = S_FETCH;
            end
            default: state_d = S_RESET;
        endcase
        // Every state change restarts the watchdog, so each wait state starts counting from zero.
        tmo_d = (state_d == state_q) ? tmo_q + TMO_W'(1) : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_RESET;
            instret_q    <= '0;
            trap_cause_q <= '0;
            tmo_q        <= '0;
            cls_q        <= '0;
            wb_q         <= 1'b0;
        end else begin
            state_q      <= state_d;
            instret_q    <= instret_d;
            trap_cause_q <= trap_cause_d;
            tmo_q        <= tmo_d;
            cls_q        <= cls_d;
            wb_q         <= wb_d;
        end
    end

    assign imem_req   = (state_q == S_FETCH);
    assign ir_we      = (state_q == S_FETCH) && imem_ack && !imem_err;
    assign dmem_req   = (state_q == S_MEMORY);
    assign dmem_wen   = (state_q == S_MEMORY) && (cls_q == C_STORE);
    assign exec_start = (state_q == S_EXECUTE) && (cls_q == C_MULTI);
    assign rf_we      = (state_q == S_WRITEBACK) && wb_q;
    assign pc_we      = (state_q == S_WRITEBACK) || (state_q == S_TRAP);
    assign trap       = (state_q == S_TRAP);
    assign halted     = (state_q == S_HALT);
    assign trap_cause = trap_cause_q;
    assign instret    = instret_q;
    assign state      = state_q;

endmodule

// File: tb/tb_rvm_ctrl_seq.sv
// tb/tb_rvm_ctrl_seq.sv - cycle-accurate check of rvm_ctrl_seq against a per-instruction trace model
module tb_rvm_ctrl_seq;

    localparam int T = 16;

    localparam logic [3:0] RST = 4'd0, FET = 4'd1, DEC = 4'd2, EXE = 4'd3, EXW = 4'd4;
    localparam logic [3:0] MEM = 4'd5, WBK = 4'd6, TRP = 4'd7, HLT = 4'd8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req, imem_ack = 1'b0, imem_err = 1'b0;
    logic        dmem_req, dmem_wen, dmem_ack = 1'b0, dmem_err = 1'b0;
    logic [2:0]  dec_class = 3'd0;
    logic        dec_wb = 1'b0, dec_illegal = 1'b0;
    logic        exec_start, exec_done = 1'b0;
    logic        ir_we, pc_we, rf_we, trap, halted;
    logic [3:0]  trap_cause, state;
    logic        halt_req = 1'b0;
    logic [63:0] instret;

    always #5 clk = ~clk;

    rvm_ctrl_seq #(.TIMEOUT(T), .TMO_W(8), .CNT_W(64)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_ack(imem_ack), .imem_err(imem_err),
        .dmem_req(dmem_req), .dmem_wen(dmem_wen), .dmem_ack(dmem_ack), .dmem_err(dmem_err),
        .dec_class(dec_class), .dec_wb(dec_wb), .dec_illegal(dec_illegal),
        .exec_start(exec_start), .exec_done(exec_done),
        .ir_we(ir_we), .pc_we(pc_we), .rf_we(rf_we), .trap(trap), .trap_cause(trap_cause),
        .halt_req(halt_req), .halted(halted), .instret(instret), .state(state)
    );

    // One entry per clock: expected state and observables, plus the inputs to drive that cycle.
    typedef struct {
        logic [3:0]  st;
        logic        rst, iack, ierr, dack, derr, done, halt;
        logic [2:0]  cls;
        logic        wb, ill;
        logic [3:0]  cause;
        logic [63:0] ir;
    } cyc_t;

    cyc_t        q[$];
    logic [3:0]  m_cause = 4'd0;
    logic [63:0] m_ir = 64'd0;
    int          pass_cnt = 0, fail_cnt = 0;

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    task automatic push(input logic [3:0] st, input logic iack, ierr, dack, derr, done, halt,
                        input logic [2:0] cls, input logic wb, ill, rst);
        cyc_t c;
        c.st = st; c.rst = rst; c.iack = iack; c.ierr = ierr; c.dack = dack; c.derr = derr;
        c.done = done; c.halt = halt; c.cls = cls; c.wb = wb; c.ill = ill;
        c.cause = m_cause; c.ir = m_ir;
        q.push_back(c);
    endtask

    // Cycle in a state where bus/exec responses must be ignored: drive them randomly.
    task automatic pf(input logic [3:0] st, input logic halt, input logic [2:0] cls, input logic wb, ill);
        push(st, rb(), rb(), rb(), rb(), rb(), halt, cls, wb, ill, 1'b0);
    endtask

    // f / lat: 1-based cycle on which the response arrives; beyond T means never (watchdog trap).
    task automatic gen(input int f, input logic ferr, input logic [2:0] cls, input logic wb, ill,
                       input int lat, input logic lerr, input logic hlt, input int hold);
        int         n;
        logic       tr, a;
        logic [3:0] cz;
        tr = 1'b0;
        cz = 4'd0;
        n = (f > T) ? T : f;
        for (int i = 1; i <= n; i++) begin
            a = (i == f);
            push(FET, a, a ? ferr : rb(), rb(), rb(), rb(), rb(), cls, wb, ill, 1'b0);
        end
        if (f > T) begin
            tr = 1'b1; cz = 4'd2;
        end else if (ferr) begin
            tr = 1'b1; cz = 4'd1;
        end else begin
            pf(DEC, rb(), cls, wb, ill);
            if (ill || cls > 3'd5) begin
                tr = 1'b1; cz = 4'd3;
            end else begin
                pf(EXE, rb(), cls, wb, ill);
                if (cls == 3'd5) begin
                    tr = 1'b1; cz = 4'd4;
                end else if (cls >= 3'd2) begin
                    n = (lat > T) ? T : lat;
                    for (int i = 1; i <= n; i++) begin
                        a = (i == lat);
                        if (cls == 3'd4) push(EXW, rb(), rb(), rb(), rb(), a, rb(), cls, wb, ill, 1'b0);
                        else             push(MEM, rb(), rb(), a, a ? lerr : rb(), rb(), rb(), cls, wb, ill, 1'b0);
                    end
                    if (lat > T) begin
                        tr = 1'b1; cz = (cls == 3'd4) ? 4'd5 : 4'd8;
                    end else if (cls != 3'd4 && lerr) begin
                        tr = 1'b1; cz = (cls == 3'd3) ? 4'd7 : 4'd6;
                    end
                end
            end
        end
        if (tr) begin
            m_cause = cz;
            pf(TRP, hlt, cls, wb, ill);
        end else begin
            pf(WBK, hlt, cls, wb, ill);
            m_ir = m_ir + 64'd1;
        end
        if (hlt) begin
            for (int i = 0; i < hold; i++) pf(HLT, 1'b1, cls, wb, ill);
            pf(HLT, 1'b0, cls, wb, ill);
        end
    endtask

    // LOAD stalled in MEMORY for k cycles, then reset while dmem_req is high.
    task automatic gen_abort(input int k);
        push(FET, 1'b1, 1'b0, rb(), rb(), rb(), rb(), 3'd2, 1'b1, 1'b0, 1'b0);
        pf(DEC, rb(), 3'd2, 1'b1, 1'b0);
        pf(EXE, rb(), 3'd2, 1'b1, 1'b0);
        for (int i = 0; i < k; i++) push(MEM, rb(), rb(), 1'b0, rb(), rb(), rb(), 3'd2, 1'b1, 1'b0, 1'b0);
        push(MEM, rb(), rb(), 1'b0, rb(), rb(), rb(), 3'd2, 1'b1, 1'b0, 1'b1);
        m_ir = 64'd0;
        m_cause = 4'd0;
        push(RST, rb(), rb(), rb(), rb(), rb(), rb(), 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        assert (got === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic play();
        cyc_t       c;
        logic [8:0] es;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(negedge clk);
            reset = c.rst; imem_ack = c.iack; imem_err = c.ierr; dmem_ack = c.dack;
            dmem_err = c.derr; exec_done = c.done; halt_req = c.halt;
            if (c.st == DEC) begin
                dec_class = c.cls; dec_wb = c.wb; dec_illegal = c.ill;
            end else begin
                dec_class = 3'($urandom); dec_wb = rb(); dec_illegal = rb();
            end
            #1;
            es = {c.st == FET, c.st == FET && c.iack && !c.ierr, c.st == MEM,
                  c.st == MEM && c.cls == 3'd3, c.st == EXE && c.cls == 3'd4,
                  c.st == WBK && c.wb, c.st == WBK || c.st == TRP, c.st == TRP, c.st == HLT};
            chk("state", 64'(state), 64'(c.st));
            chk("strobes", 64'({imem_req, ir_we, dmem_req, dmem_wen, exec_start, rf_we, pc_we, trap, halted}), 64'(es));
            chk("trap_cause", 64'(trap_cause), 64'(c.cause));
            chk("instret", instret, c.ir);
        end
    endtask

    initial begin
        push(RST, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        pf(RST, rb(), 3'd0, 1'b0, 1'b0);
        gen(1, 0, 3'd0, 1, 0, 0, 0, 0, 0);
        gen(1, 0, 3'd2, 1, 0, 3, 0, 0, 0);
        gen(2, 0, 3'd3, 0, 0, 2, 1, 0, 0);
        gen(T + 1, 0, 3'd0, 1, 0, 0, 0, 0, 0);
        gen(T, 0, 3'd1, 0, 0, 0, 0, 0, 0);
        gen(1, 0, 3'd4, 1, 0, 10, 0, 0, 0);
        gen(1, 0, 3'd4, 1, 0, T + 1, 0, 0, 0);
        gen(1, 0, 3'd4, 1, 0, T, 0, 0, 0);
        gen(1, 0, 3'd2, 1, 0, T + 1, 0, 0, 0);
        gen(1, 0, 3'd3, 0, 0, T, 0, 0, 0);
        gen(1, 0, 3'd2, 1, 0, 1, 1, 0, 0);
        gen(3, 0, 3'd2, 1, 0, 4, 0, 1, 2);
        gen(1, 0, 3'd5, 0, 0, 0, 0, 1, 0);
        gen(2, 1, 3'd0, 1, 0, 0, 0, 0, 0);
        gen(1, 0, 3'd6, 1, 0, 0, 0, 0, 0);
        gen(1, 0, 3'd0, 1, 1, 0, 0, 0, 0);
        gen(1, 0, 3'd3, 1, 0, 1, 1, 0, 0);
        gen_abort(2);
        gen(1, 0, 3'd7, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 80; i++) begin
            gen($urandom_range(1, T + 2), ($urandom % 6) == 0, 3'($urandom), rb(),
                ($urandom % 8) == 0, $urandom_range(1, T + 2), ($urandom % 6) == 0,
                ($urandom % 5) == 0, $urandom_range(0, 3));
        end
        play();
        $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
        $finish;
    end

endmodule

// File: doc/rvm_ctrl_seq.md
Name: rvm_ctrl_seq

Overview:
Parametrised next-generation main control sequencer for the multi-cycle RISC-V core. It sequences fetch/decode/execute/memory/writeback and adds four things:
- variable-latency bus handshakes on both memory ports;
- a multi-cycle execute unit handshake (mul/div);
- watchdog timeouts that raise precise traps;
- a debug halt handshake and a retired-instruction counter.

It sits between the bus interfaces, the decoder and the datapath, and drives all datapath write enables.

Parameters:
TIMEOUT, 16, cycles a wait state may stall before trapping; 0 disables all timeouts
TMO_W, 8, timeout counter width; TIMEOUT < 2**TMO_W
CNT_W, 64, width of instret counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
imem_req  out  1  instruction fetch request, held until ack
imem_ack  in  1  fetch completes this cycle
imem_err  in  1  fetch bus error, qualified by imem_ack
dmem_req  out  1  data request, held until ack
dmem_wen  out  1  1 = store, 0 = load; valid with dmem_req
dmem_ack  in  1  data access completes this cycle
dmem_err  in  1  data bus error, qualified by dmem_ack
dec_class  in  3  0 ALU, 1 BRANCH, 2 LOAD, 3 STORE, 4 MULTI, 5 SYSTEM, others illegal
dec_wb  in  1  instruction writes rd
dec_illegal  in  1  decoder flags illegal encoding
exec_start  out  1  one-cycle start pulse to multi-cycle unit
exec_done  in  1  multi-cycle result ready
ir_we  out  1  latch instruction register
pc_we  out  1  update PC (datapath selects trap vector when trap=1)
rf_we  out  1  register file write
trap  out  1  trap taken this cycle
trap_cause  out  4  cause of last trap, held until next trap
halt_req  in  1  debug halt request, level
halted  out  1  core parked at instruction boundary
instret  out  CNT_W  retired instruction count
state  out  4  current state encoding (debug)

Behaviour:
- States and encodings: RESET=0, FETCH=1, DECODE=2, EXECUTE=3, EXEC_WAIT=4, MEMORY=5, WRITEBACK=6, TRAP=7, HALT=8. Unused encodings go to RESET next cycle.
- Reset:
  - at any clk edge with reset=1: state<=RESET, instret<=0, trap_cause<=0, timeout counter<=0, latched class<=0. This includes mid-transaction; the outstanding request is simply dropped.
  - All strobe outputs are decoded from state and are 0 in RESET.
  - RESET -> FETCH unconditionally on the first edge with reset=0.
- Timeout counter:
  - cleared on entry to FETCH, EXEC_WAIT and MEMORY; increments each cycle spent there without ack/done.
  - A timeout fires in the cycle where counter==TIMEOUT-1 and no ack/done. So a stall of TIMEOUT cycles traps, while an ack on cycle TIMEOUT is accepted.
  - ack/done in the same cycle as the limit: ack/done wins.
- FETCH: imem_req=1.
  - imem_ack & !imem_err: ir_we=1, go to DECODE.
  - imem_ack & imem_err: go to TRAP, cause 1.
  - timeout: go to TRAP, cause 2.
- DECODE: dec_class, dec_wb and dec_illegal are sampled into internal registers; later states use only the latched copies.
  - dec_illegal or class > 5: go to TRAP, cause 3.
  - otherwise go to EXECUTE.
- EXECUTE (1 cycle):
  - ALU/BRANCH: go to WRITEBACK.
  - LOAD/STORE: go to MEMORY.
  - MULTI: exec_start=1, go to EXEC_WAIT.
  - SYSTEM: go to TRAP, cause 4.
- EXEC_WAIT: exec_done goes to WRITEBACK; timeout goes to TRAP, cause 5. exec_done during EXECUTE is ignored.
- MEMORY: dmem_req=1, dmem_wen=(class==STORE).
  - ack & !err: go to WRITEBACK.
  - ack & err: go to TRAP, cause 6 (load) or 7 (store).
  - timeout: go to TRAP, cause 8.
- WRITEBACK (1 cycle): rf_we=latched dec_wb, pc_we=1, instret<=instret+1 (wraps modulo 2**CNT_W). Next state is HALT if halt_req else FETCH.
- TRAP (1 cycle): trap=1, pc_we=1, trap_cause updated on entry so it is valid during TRAP. Not counted in instret. Next state is HALT if halt_req else FETCH.
- HALT: halted=1, all strobes 0. Go to FETCH on the first cycle with halt_req=0.
- halt_req only takes effect at WRITEBACK/TRAP boundaries. An in-flight instruction or trap always completes first.
- imem_ack/dmem_ack outside their wait state are ignored.

Test Plan:
- Reset then ALU op with dec_wb=1, imem_ack on 1st FETCH cycle: states 0->1->2->3->6->1; rf_we=1 and pc_we=1 for one cycle; instret 0->1.
- LOAD with dmem_ack on 3rd MEMORY cycle: dmem_req=1 for exactly 3 cycles with dmem_wen=0, then WRITEBACK. STORE with dmem_err on ack: TRAP, trap_cause=7, instret unchanged.
- TIMEOUT=4, imem_ack never: FETCH held 4 cycles, then TRAP with trap_cause=2. Repeat with ack on cycle 4: DECODE, no trap.
- MULTI op with exec_done after 10 cycles (TIMEOUT=16): exec_start pulses once in EXECUTE; EXEC_WAIT lasts 10 cycles; then WRITEBACK.
- halt_req raised mid-MEMORY: instruction retires, state goes to HALT with halted=1. Deassert halt_req: FETCH next cycle.
- reset asserted during MEMORY with dmem_req=1: next edge gives state=0, dmem_req=0, instret=0, trap_cause=0. Illegal decode after restart: trap_cause=3.
